find_peak_win: RTL and testbench
================================

# find_peak_win

Streaming frame peak finder. For each AXI-Stream frame it reports the maximum sample, its index within the frame, and a window of NEIGH samples on each side of the peak. It is the parametrised successor of the team's fixed 3-sample max finder:
- internal index counter
- signed/unsigned compare
- configurable window width
- real output handshake with backpressure

It sits after FFT magnitude / ADC capture blocks, feeding peak interpolation logic.

## Interface
Parameters:
- DATA_WIDTH, 8, sample width
- ADDR_WIDTH, 6, index counter width; frames up to 2^ADDR_WIDTH samples
- NEIGH, 1, samples captured each side of peak (1..8)
- SIGNED, 0, 1 = two's-complement compare, 0 = unsigned

Ports:
- clk_in  in  1  clock
- rst  in  1  reset, synchronous, active-high
- s_axis_tvalid  in  1  input sample valid
- s_axis_tready  out  1  input ready
- s_axis_tdata  in  DATA_WIDTH  input sample
- s_axis_tlast  in  1  last sample of frame
- m_axis_tvalid  out  1  result valid
- m_axis_tready  in  1  result accepted
- m_axis_tdata  out  (2*NEIGH+1)*DATA_WIDTH  window; slot k at bits [k*DATA_WIDTH +: DATA_WIDTH], slot NEIGH = peak, slot 0 = index peak-NEIGH
- m_axis_taddr  out  ADDR_WIDTH  peak index in frame (first sample = 0)
- m_axis_tovf  out  1  frame exceeded 2^ADDR_WIDTH samples

## Operation
- Beat = s_axis_tvalid & s_axis_tready. Non-beat cycles change no state.
- s_axis_tready = ~m_axis_tvalid | m_axis_tready. Input stalls only while a result is pending and not accepted.
- Working state:
  - idx counter
  - first flag (next beat starts a frame)
  - hist[NEIGH-1:0]: last NEIGH samples of the current frame; zero at frame start
  - pre[NEIGH], peak, post[NEIGH]
  - post_cnt (0..NEIGH)
  - peak_idx, ovf
- First beat of a frame:
  - peak <= data, peak_idx <= 0
  - pre <= all zero, post <= all zero, post_cnt <= 0
  - the first sample always loads, whatever its value
- Later beats:
  - new max if data > peak (strict, signed or unsigned per SIGNED). Ties keep the earlier peak.
  - on new max: pre <= hist, peak <= data, peak_idx <= idx, post <= zero, post_cnt <= 0.
  - otherwise, if post_cnt < NEIGH: post[post_cnt] <= data, post_cnt++.
- Every beat shifts data into hist.
- idx increments per beat and saturates at 2^ADDR_WIDTH-1.
  - A beat arriving with idx already saturated sets ovf.
  - Peaks found after saturation report the saturated index.
- Beat with tlast:
  - the tlast sample is processed as above.
  - the result register (window, peak_idx, ovf) is loaded with the post-update values. Unfilled post slots and pre slots before index 0 read zero.
  - m_axis_tvalid <= 1, first <= 1, hist cleared.
- Result register holds until the m_axis handshake, then m_axis_tvalid <= 0, unless a new tlast beat occurs in the same cycle. In that case the new result loads and m_axis_tvalid stays 1.
- Single-beat frame (first + tlast): window = {0.., sample, 0..}, addr 0.

## Timing
- Reset values:
  - m_axis_tvalid 0, m_axis_tdata 0, m_axis_taddr 0, m_axis_tovf 0
  - s_axis_tready 1
  - all working state cleared, first = 1
- Reset mid-frame discards the partial frame and any pending result.
- Throughput: 1 sample/cycle; no dead cycles between frames.
- Latency: m_axis_tvalid asserts the cycle after the tlast beat.
- Outputs are registered. s_axis_tready is combinational from m_axis_tvalid/m_axis_tready only.
- m_axis_tdata, taddr and tovf are stable while m_axis_tvalid=1 and m_axis_tready=0.

## Test plan
- Defaults (NEIGH=1, unsigned): frame 3,7,5,2 (tlast on 2). Required: one cycle later tvalid=1, window {3,7,5} (slot0=3), taddr=1, tovf=0.
- Edge peaks:
  - frame 9,1,2 -> window {0,9,1}, taddr=0
  - frame 1,2,9 -> window {2,9,0}, taddr=2
  - single-beat frame 6 -> {0,6,0}, taddr=0
- Ties and restart: frame 4,8,8,1 -> {4,8,8}, taddr=1. NEIGH=2 frame 1,5,2,6,3,0 -> {5,2,6,3,0}, taddr=3.
- SIGNED=1: frame 0xF0,0x05,0x80 -> peak 0x05, taddr=1. SIGNED=0 build, same frame -> peak 0xF0, taddr=0, window {0,0xF0,0x05}.
- Backpressure and back-to-back frames:
  - hold m_axis_tready=0 after a frame -> s_axis_tready=0, outputs stable for 10 cycles.
  - raise m_axis_tready -> s_axis_tready=1 the same cycle.
  - a second frame whose tlast coincides with acceptance -> tvalid stays 1 with the new result.
- Overflow and reset: ADDR_WIDTH=3, 10-sample frame, max at sample 9 -> taddr=7, tovf=1. Assert rst mid-frame, then send frame 2,3 -> {2,3,0}, taddr=1, no stale data.

Source files
------------

// File: rtl/find_peak_win.sv
// find_peak_win: streaming per-frame peak finder reporting the max sample, its index and NEIGH neighbours each side
// Ports:
//   clk_in, rst                          clock, synchronous active-high reset
//   s_axis_tvalid/tready/tdata/tlast     sample stream in
//   m_axis_tvalid/tready                 result handshake
//   m_axis_tdata                         window, slot k at [k*DATA_WIDTH +: DATA_WIDTH], slot NEIGH = peak
//   m_axis_taddr                         peak index within the frame (saturating)
//   m_axis_tovf                          frame longer than 2^ADDR_WIDTH samples
module find_peak_win #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int NEIGH      = 1,
    parameter int SIGNED     = 0
) (
    input  logic                                clk_in,
    input  logic                                rst,
    input  logic                                s_axis_tvalid,
    output logic                                s_axis_tready,
    input  logic [DATA_WIDTH-1:0]               s_axis_tdata,
    input  logic                                s_axis_tlast,
    output logic                                m_axis_tvalid,
    input  logic                                m_axis_tready,
    output logic [(2*NEIGH+1)*DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [ADDR_WIDTH-1:0]               m_axis_taddr,
    output logic                                m_axis_tovf
);
    localparam int PW = $clog2(NEIGH + 1);
    localparam logic [PW-1:0] NP = PW'(NEIGH);
    localparam logic [ADDR_WIDTH-1:0] IMAX = '1;
    typedef logic [DATA_WIDTH-1:0] smp_t;
    smp_t hist[NEIGH], pre[NEIGH], post[NEIGH], n_pre[NEIGH], n_post[NEIGH];
    smp_t peak, n_peak;
    logic [PW-1:0] pcnt, n_pcnt;
    logic [ADDR_WIDTH-1:0] idx, pidx, n_pidx;
    logic first, sat, ovf, n_ovf, gt, beat;
    logic [(2*NEIGH+1)*DATA_WIDTH-1:0] win;
    assign s_axis_tready = ~m_axis_tvalid | m_axis_tready;
    assign beat = s_axis_tvalid & s_axis_tready;
    assign gt = (SIGNED != 0) ? ($signed(s_axis_tdata) > $signed(peak)) : (s_axis_tdata > peak);
    // Post-update working state for the current beat; also the value captured into the result on tlast.
    // sat marks that the index counter already reached its top, so any further beat is an overflow.
    always_comb begin
        n_pre = pre;
        n_post = post;
        n_peak = peak;
        n_pcnt = pcnt;
        n_pidx = pidx;
        n_ovf = first ? 1'b0 : (ovf | sat);
        if (first || gt) begin
            for (int k = 0; k < NEIGH; k++) begin
                n_pre[k] = first ? '0 : hist[k];
                n_post[k] = '0;
            end
            n_peak = s_axis_tdata;
            n_pidx = first ? '0 : idx;
            n_pcnt = '0;
        end else if (pcnt < NP) begin
            for (int k = 0; k < NEIGH; k++)
                if (PW'(k) == pcnt) n_post[k] = s_axis_tdata;
            n_pcnt = pcnt + 1'b1;
        end
        for (int k = 0; k < NEIGH; k++) begin
            win[k*DATA_WIDTH +: DATA_WIDTH] = n_pre[k];
            win[(NEIGH+1+k)*DATA_WIDTH +: DATA_WIDTH] = n_post[k];
        end
        win[NEIGH*DATA_WIDTH +: DATA_WIDTH] = n_peak;
    end
    // hist[0] is the oldest of the last NEIGH samples, so it lines up with pre slot 0.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            first <= 1'b1;
            idx <= '0;
            sat <= 1'b0;
            ovf <= 1'b0;
            peak <= '0;
            pidx <= '0;
            pcnt <= '0;
            for (int k = 0; k < NEIGH; k++) begin
                hist[k] <= '0;
                pre[k] <= '0;
                post[k] <= '0;
            end
            m_axis_tvalid <= 1'b0;
            m_axis_tdata <= '0;
            m_axis_taddr <= '0;
            m_axis_tovf <= 1'b0;
        end else begin
            if (m_axis_tready) m_axis_tvalid <= 1'b0;
            if (beat) begin
                pre <= n_pre;
                post <= n_post;
                peak <= n_peak;
                pcnt <= n_pcnt;
                pidx <= n_pidx;
                ovf <= n_ovf;
                first <= s_axis_tlast;
                sat <= s_axis_tlast ? 1'b0 : (sat | (idx == IMAX));
                idx <= s_axis_tlast ? '0 : ((idx == IMAX) ? idx : idx + 1'b1);
                for (int k = 0; k < NEIGH-1; k++) hist[k] <= s_axis_tlast ? '0 : hist[k+1];
                hist[NEIGH-1] <= s_axis_tlast ? '0 : s_axis_tdata;
                if (s_axis_tlast) begin
                    m_axis_tvalid <= 1'b1;
                    m_axis_tdata <= win;
                    m_axis_taddr <= n_pidx;
                    m_axis_tovf <= n_ovf;
                end
            end
        end
    end
endmodule

// File: tb/tb_find_peak_win.sv
// tb_find_peak_win: table, hand-written and random frames on four find_peak_win builds sharing one stream
module tb_find_peak_win;
    logic clk = 0, rst = 1, s_valid = 0, s_last = 0, m_tready = 1;
    logic [7:0] s_data = 0;
    logic rdy0, rdy1, rdy2, rdy3, v0, v1, v2, v3, o0, o1, o2, o3;
    logic [23:0] d0, d2, d3, hold_d;
    logic [39:0] d1;
    logic [5:0] a0, a1, a2, hold_a;
    logic [2:0] a3;
    logic hold_o;
    int total = 0, pass = 0;
    logic [7:0] fr[$];

    always #5 clk = ~clk;

    find_peak_win u0 (.clk_in(clk), .rst(rst), .s_axis_tvalid(s_valid), .s_axis_tready(rdy0), .s_axis_tdata(s_data),
        .s_axis_tlast(s_last), .m_axis_tvalid(v0), .m_axis_tready(m_tready), .m_axis_tdata(d0), .m_axis_taddr(a0), .m_axis_tovf(o0));
    find_peak_win #(.NEIGH(2)) u1 (.clk_in(clk), .rst(rst), .s_axis_tvalid(s_valid), .s_axis_tready(rdy1), .s_axis_tdata(s_data),
        .s_axis_tlast(s_last), .m_axis_tvalid(v1), .m_axis_tready(m_tready), .m_axis_tdata(d1), .m_axis_taddr(a1), .m_axis_tovf(o1));
    find_peak_win #(.SIGNED(1)) u2 (.clk_in(clk), .rst(rst), .s_axis_tvalid(s_valid), .s_axis_tready(rdy2), .s_axis_tdata(s_data),
        .s_axis_tlast(s_last), .m_axis_tvalid(v2), .m_axis_tready(m_tready), .m_axis_tdata(d2), .m_axis_taddr(a2), .m_axis_tovf(o2));
    find_peak_win #(.ADDR_WIDTH(3)) u3 (.clk_in(clk), .rst(rst), .s_axis_tvalid(s_valid), .s_axis_tready(rdy3), .s_axis_tdata(s_data),
        .s_axis_tlast(s_last), .m_axis_tvalid(v3), .m_axis_tready(m_tready), .m_axis_tdata(d3), .m_axis_taddr(a3), .m_axis_tovf(o3));

    typedef struct { int n; logic [7:0] s[8]; logic [23:0] w; int a; } vec_t;
    vec_t tbl[7];

    task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    function automatic bit gtr(input logic [7:0] x, input logic [7:0] y, input int sgn);
        return sgn != 0 ? ($signed(x) > $signed(y)) : (x > y);
    endfunction

    // Reference: first strict maximum of the frame, neighbours read straight from the sample list.
    task automatic model(input int neigh, input int sgn, input int aw, output logic [39:0] w, output logic [39:0] a, output logic [39:0] o);
        int p = 0, n = fr.size(), lim = (1 << aw) - 1;
        for (int i = 1; i < n; i++) if (gtr(fr[i], fr[p], sgn)) p = i;
        w = '0;
        for (int j = 0; j <= 2*neigh; j++) begin
            int k = p - neigh + j;
            if (k >= 0 && k < n) w[j*8 +: 8] = fr[k];
        end
        a = 40'(p > lim ? lim : p);
        o = 40'(n > lim + 1);
    endtask

    task automatic check_all(input string tag);
        logic [39:0] w, a, o;
        model(1, 0, 6, w, a, o);
        chk({tag, "/u0.valid"}, 40'(v0), 1); chk({tag, "/u0.data"}, 40'(d0), w);
        chk({tag, "/u0.addr"}, 40'(a0), a); chk({tag, "/u0.ovf"}, 40'(o0), o);
        model(2, 0, 6, w, a, o);
        chk({tag, "/u1.valid"}, 40'(v1), 1); chk({tag, "/u1.data"}, d1, w);
        chk({tag, "/u1.addr"}, 40'(a1), a); chk({tag, "/u1.ovf"}, 40'(o1), o);
        model(1, 1, 6, w, a, o);
        chk({tag, "/u2.valid"}, 40'(v2), 1); chk({tag, "/u2.data"}, 40'(d2), w);
        chk({tag, "/u2.addr"}, 40'(a2), a); chk({tag, "/u2.ovf"}, 40'(o2), o);
        model(1, 0, 3, w, a, o);
        chk({tag, "/u3.valid"}, 40'(v3), 1); chk({tag, "/u3.data"}, 40'(d3), w);
        chk({tag, "/u3.addr"}, 40'(a3), a); chk({tag, "/u3.ovf"}, 40'(o3), o);
    endtask

    // Drives fr as consecutive beats; returns on the negedge after the final beat.
    task automatic send_fr(input bit with_last);
        int t;
        for (int i = 0; i < fr.size(); i++) begin
            @(negedge clk);
            s_valid = 1;
            s_data = fr[i];
            s_last = with_last && (i == fr.size() - 1);
            t = 0;
            while (!rdy0 && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (t == 50) begin
                $display("FAIL send_fr.ready: got %0b want 1", rdy0);
                $fatal(1);
            end
            @(posedge clk);
        end
        @(negedge clk);
        s_valid = 0;
        s_last = 0;
    endtask

    initial begin
        tbl[0] = '{4, '{8'h03, 8'h07, 8'h05, 8'h02, 0, 0, 0, 0}, 24'h050703, 1};
        tbl[1] = '{3, '{8'h09, 8'h01, 8'h02, 0, 0, 0, 0, 0}, 24'h010900, 0};
        tbl[2] = '{3, '{8'h01, 8'h02, 8'h09, 0, 0, 0, 0, 0}, 24'h000902, 2};
        tbl[3] = '{1, '{8'h06, 0, 0, 0, 0, 0, 0, 0}, 24'h000600, 0};
        tbl[4] = '{4, '{8'h04, 8'h08, 8'h08, 8'h01, 0, 0, 0, 0}, 24'h080804, 1};
        tbl[5] = '{3, '{8'hF0, 8'h05, 8'h80, 0, 0, 0, 0, 0}, 24'h05F000, 0};
        tbl[6] = '{6, '{8'h01, 8'h05, 8'h02, 8'h06, 8'h03, 8'h00, 0, 0}, 24'h030602, 3};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 0;
        chk("reset.valid", 40'(v0), 0);
        chk("reset.data", 40'(d0), 0);
        chk("reset.addr", 40'(a0), 0);
        chk("reset.ovf", 40'(o0), 0);
        chk("reset.ready", 40'(rdy0), 1);

        foreach (tbl[i]) begin
            fr = {};
            for (int j = 0; j < tbl[i].n; j++) fr.push_back(tbl[i].s[j]);
            send_fr(1);
            chk($sformatf("tbl%0d.data", i), 40'(d0), 40'(tbl[i].w));
            chk($sformatf("tbl%0d.addr", i), 40'(a0), 40'(tbl[i].a));
            check_all($sformatf("tbl%0d", i));
        end

        fr = {8'h01, 8'h05, 8'h02, 8'h06, 8'h03, 8'h00};
        send_fr(1);
        chk("neigh2.data", d1, 40'h0003060205);
        chk("neigh2.addr", 40'(a1), 3);
        fr = {8'hF0, 8'h05, 8'h80};
        send_fr(1);
        chk("signed.data", 40'(d2), 40'h8005F0);
        chk("signed.addr", 40'(a2), 1);

        fr = {};
        for (int i = 1; i <= 8; i++) fr.push_back(8'(i));
        send_fr(1);
        chk("full8.addr", 40'(a3), 7);
        chk("full8.ovf", 40'(o3), 0);
        chk("full8.data", 40'(d3), 40'h000807);
        fr = {};
        for (int i = 1; i <= 10; i++) fr.push_back(8'(i));
        send_fr(1);
        chk("ovf10.addr", 40'(a3), 7);
        chk("ovf10.ovf", 40'(o3), 1);
        chk("ovf10.data", 40'(d3), 40'h000A09);
        chk("ovf10.u0addr", 40'(a0), 9);
        check_all("ovf10");

        @(negedge clk);
        m_tready = 0;
        fr = {8'h03, 8'h07, 8'h05, 8'h02};
        send_fr(1);
        hold_d = d0; hold_a = a0; hold_o = o0;
        chk("bp.data", 40'(hold_d), 40'h050703);
        for (int i = 0; i < 10; i++) begin
            chk("bp.ready", 40'(rdy0), 0);
            chk("bp.valid", 40'(v0), 1);
            chk("bp.stable", {15'b0, hold_o, hold_a, d0}, {15'b0, o0, a0, hold_d});
            @(negedge clk);
        end
        m_tready = 1;
        #1;
        chk("bp.ready_comb", 40'(rdy0), 1);
        s_valid = 1; s_data = 8'h06; s_last = 1;
        @(posedge clk);
        @(negedge clk);
        s_valid = 0; s_last = 0;
        chk("b2b.valid", 40'(v0), 1);
        chk("b2b.data", 40'(d0), 40'h000600);
        chk("b2b.addr", 40'(a0), 0);

        m_tready = 0;
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("rstpend.valid", 40'(v0), 0);
        chk("rstpend.data", 40'(d0), 0);
        m_tready = 1;
        fr = {8'h05, 8'h09};
        send_fr(0);
        rst = 1;
        @(negedge clk);
        rst = 0;
        fr = {8'h02, 8'h03};
        send_fr(1);
        chk("rstmid.data", 40'(d0), 40'h000302);
        chk("rstmid.addr", 40'(a0), 1);
        check_all("rstmid");

        for (int f = 0; f < 40; f++) begin
            int n = $urandom_range(1, 12);
            fr = {};
            for (int i = 0; i < n; i++)
                fr.push_back($urandom_range(0, 1) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 3)));
            send_fr(1);
            check_all($sformatf("rnd%0d", f));
        end

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
